// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: access modes,
// FSM state, requester IDs and the access legality check.
package dmem_pkg;

  localparam logic [3:0] BYTE  = 4'd0;
  localparam logic [3:0] HALF  = 4'd1;
  localparam logic [3:0] WORD  = 4'd2;
  localparam logic [3:0] UBYTE = 4'd3;
  localparam logic [3:0] UHALF = 4'd4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  // Misaligned, out of range, unknown mode, or an unsigned-extension store
  function automatic logic access_err(input logic        we,
                                      input logic [3:0]  mode,
                                      input logic [31:0] addr,
                                      input logic [31:0] mem_words);
    logic bad_mode;
    bad_mode = (mode > UHALF) || (we && ((mode == UBYTE) || (mode == UHALF)));
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= mem_words) || bad_mode;
  endfunction

endpackage

// File: rtl/dmem_grant.sv
// Combinational grant and priority-pointer update for the two requesters.
// Optional feature: DMEM_ARB_ROUND_ROBIN_EN selects round-robin on contention.
module dmem_grant
  import dmem_pkg::*;
(
  input  logic cpu_valid,
  input  logic dma_valid,
  input  logic prio,
  output logic grant,
  output logic prio_next
);

  // A lone requester always wins; contention and the idle case follow prio
  always_comb begin
    grant = prio;
    if (cpu_valid && !dma_valid) begin
      grant = REQ_CPU;
    end else if (dma_valid && !cpu_valid) begin
      grant = REQ_DMA;
    end else begin
      grant = prio;
    end
  end

  // Pointer names the requester favoured at the next contention
  always_comb begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (grant == REQ_CPU) begin
      prio_next = REQ_DMA;
    end else begin
      prio_next = REQ_CPU;
    end
`else
    prio_next = REQ_CPU;
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU/DMA) arbiter for a shared data memory, one access per two cycles.
// Optional feature: DMEM_ARB_ROUND_ROBIN_EN (round-robin instead of CPU priority).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_mode,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rsp_err,
  input  logic        dma_req_valid,
  output logic        dma_req_ready,
  input  logic        dma_we,
  input  logic [3:0]  dma_mode,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_rsp_valid,
  output logic [31:0] dma_rdata,
  output logic        dma_rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_mode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_t      state_r;
  state_t      state_next_s;
  logic        prio_r;
  logic        prio_next_s;
  logic        grant_s;
  logic        owner_r;
  logic        cap_we_r;
  logic        cap_err_r;
  logic        sel_valid_s;
  logic        sel_we_s;
  logic [3:0]  sel_mode_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        sel_err_s;
  logic        accept_s;

  dmem_grant u_grant (
    .cpu_valid (cpu_req_valid),
    .dma_valid (dma_req_valid),
    .prio      (prio_r),
    .grant     (grant_s),
    .prio_next (prio_next_s)
  );

  // Route the granted requester's fields to the capture path
  always_comb begin
    if (grant_s == REQ_DMA) begin
      sel_valid_s = dma_req_valid;
      sel_we_s    = dma_we;
      sel_mode_s  = dma_mode;
      sel_addr_s  = dma_addr;
      sel_wdata_s = dma_wdata;
    end else begin
      sel_valid_s = cpu_req_valid;
      sel_we_s    = cpu_we;
      sel_mode_s  = cpu_mode;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
  end

  assign sel_err_s = access_err(sel_we_s, sel_mode_s, sel_addr_s, MEM_WORDS_W);
  assign accept_s  = (state_r == IDLE) && sel_valid_s;

  // Ready goes to the granted requester only in IDLE and never while reset is held
  always_comb begin
    cpu_req_ready = 1'b0;
    dma_req_ready = 1'b0;
    if (rst_n && (state_r == IDLE)) begin
      if (grant_s == REQ_DMA) begin
        dma_req_ready = 1'b1;
      end else begin
        cpu_req_ready = 1'b1;
      end
    end else begin
      cpu_req_ready = 1'b0;
      dma_req_ready = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = accept_s ? ACCESS : IDLE;
      ACCESS:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture on accept; memory strobes are live only for the ACCESS cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r    <= REQ_CPU;
      owner_r   <= REQ_CPU;
      cap_we_r  <= 1'b0;
      cap_err_r <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_mode  <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else if (accept_s) begin
      prio_r    <= prio_next_s;
      owner_r   <= grant_s;
      cap_we_r  <= sel_we_s;
      cap_err_r <= sel_err_s;
      mem_read  <= !sel_we_s && !sel_err_s;
      mem_write <= sel_we_s && !sel_err_s;
      mem_mode  <= sel_mode_s;
      mem_addr  <= {2'b00, sel_addr_s[31:2]};
      mem_wdata <= sel_wdata_s;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  // Completion: one-cycle pulse to the owner; data and error hold until its next response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rsp_valid <= 1'b0;
      cpu_rdata     <= 32'd0;
      cpu_rsp_err   <= 1'b0;
      dma_rsp_valid <= 1'b0;
      dma_rdata     <= 32'd0;
      dma_rsp_err   <= 1'b0;
    end else if (state_r == ACCESS) begin
      if (owner_r == REQ_DMA) begin
        cpu_rsp_valid <= 1'b0;
        dma_rsp_valid <= 1'b1;
        dma_rdata     <= (cap_err_r || cap_we_r) ? 32'd0 : mem_rdata;
        dma_rsp_err   <= cap_err_r;
      end else begin
        dma_rsp_valid <= 1'b0;
        cpu_rsp_valid <= 1'b1;
        cpu_rdata     <= (cap_err_r || cap_we_r) ? 32'd0 : mem_rdata;
        cpu_rsp_err   <= cap_err_r;
      end
    end else begin
      cpu_rsp_valid <= 1'b0;
      dma_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64: number of 32-bit words in the shared data memory.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-003 clk  in  1  rising-edge clock for all arbiter state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cpu_req_valid  in  1  CPU load/store request; cpu_req_ready out 1 accept.
REQ-006 cpu_we in 1 write; cpu_mode in 4 access mode; cpu_addr in 32 byte address; cpu_wdata in 32 store data.
REQ-007 cpu_rsp_valid out 1 one-cycle completion pulse; cpu_rdata out 32 load data; cpu_rsp_err out 1 access rejected.
REQ-008 dma_* SHALL mirror REQ-005..007 exactly for the second requester.
REQ-009 mem_read out 1, mem_write out 1, mem_mode out 4, mem_addr out 32 word index, mem_wdata out 32, mem_rdata in 32 (combinational read data from the memory).

Function
REQ-010 FSM states: IDLE, ACCESS; one request served per two cycles.
REQ-011 In IDLE, the ready of the granted requester SHALL be 1 and the other SHALL be 0; both readies SHALL be 0 in ACCESS.
REQ-012 Grant when only one valid: that requester; when both valid: per REQ-025.
REQ-013 On valid&ready at edge N: capture we, mode, addr, wdata, requester ID, and go to ACCESS for cycle N+1.
REQ-014 In ACCESS: mem_addr={2'b0,addr[31:2]}; mem_mode=captured mode; mem_read=!we; mem_write=we; mem_wdata=captured wdata.
REQ-015 At the edge ending ACCESS: register mem_rdata (0 for writes) into the owner's rdata, pulse the owner's rsp_valid for exactly one cycle (N+2), and return to IDLE.
REQ-016 A new request SHALL be accepted in the same cycle as the previous rsp_valid pulse.
REQ-017 Error: addr[1:0]!=0, addr[31:2]>=MEM_WORDS, or mode not in {0..4} -> mem_read=mem_write=0 during ACCESS, rsp_err=1 with rsp_valid, rdata=0.
REQ-018 Writes with mode UBYTE(3) or UHALF(4) SHALL be errors.
REQ-019 mem_read/mem_write SHALL be 0 in IDLE; other mem_* SHALL hold their last values.
REQ-020 rdata and rsp_err SHALL hold until the next response to the same requester.
REQ-021 Valid deasserted before acceptance is legal; nothing is captured.

Reset
REQ-022 rst_n low SHALL force IDLE, all readies 0 for the reset cycle, rsp_valid=0, rsp_err=0, rdata=0, mem_read=mem_write=0, mem_addr=mem_wdata=0, mem_mode=0, priority pointer=CPU.
REQ-023 Reset during ACCESS SHALL abort the access with no response pulse; a write in flight is not guaranteed to land.
REQ-024 After release, the first accept SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-025 Macro DMEM_ARB_ROUND_ROBIN_EN defined: on contention, grant the requester not served last (pointer updates on each accept, starting at CPU). Undefined: fixed priority, CPU always wins contention.

Structure
REQ-026 Package dmem_pkg SHALL hold the mode constants BYTE=0, HALF=1, WORD=2, UBYTE=3, UHALF=4, the FSM state type, and the requester-ID type.
REQ-027 Sub-module dmem_grant SHALL implement the combinational grant and pointer logic; the FSM and capture registers stay in dmem_arbiter.

Verification
REQ-028 CPU WORD write addr 0x8 data 0xDEADBEEF, then a WORD read -> mem_addr=2, mem_write=1 for one cycle, rsp pulses at N+2, rdata=0xDEADBEEF.
REQ-029 Word 0 = 0x000000F0; CPU BYTE read -> rdata 0xFFFFFFF0; UBYTE read -> rdata 0x000000F0.
REQ-030 Both valid continuously for 4 grants -> with the macro: CPU,DMA,CPU,DMA; without the macro: CPU,CPU,CPU,CPU.
REQ-031 DMA read addr 0x102 -> rsp_err=1, rdata=0, mem_read never asserted; DMA read addr 0x100 (word 64) -> rsp_err=1.
REQ-032 rst_n low during ACCESS -> no rsp_valid pulse, all outputs at reset values; the next request after release completes normally.
